// File: rtl/pcs_receptor.sv
// 1000BASE-X PCS receive: 8b/10b decode, delimiter detection (/S/ /T/ /R/, idles)
// and registered GMII-style RXD/RX_DV/RX_ER generation.
module pcs_receptor #(
    parameter logic [7:0] PREAMBLE_OCTET = 8'h55,
    parameter logic [7:0] ERR_OCTET      = 8'h0E
) (
    input  logic       GTX_CLK,
    input  logic       RESET,
    input  logic [9:0] rx_code_group,
    input  logic       rx_even,
    input  logic       sync_status,
    input  logic       SUDI,
    output logic [7:0] RXD,
    output logic       RX_DV,
    output logic       RX_ER,
    output logic       receiving
);

    typedef enum logic [2:0] {
        LINK_FAILED,
        WAIT_FOR_K,
        RX_K,
        IDLE_D,
        RECEIVE,
        END_T,
        END_R
    } state_t;

    state_t state, state_d;

    logic [5:0] abcdei;
    logic [3:0] fghj;
    logic       valid6, valid4;
    logic [4:0] edcba;
    logic [2:0] hgf;
    logic       data_valid;
    logic [7:0] data_octet;

    logic is_k28_5, is_s, is_t, is_r, is_idle_d;

    logic [7:0] rxd_d;
    logic       rx_dv_d, rx_er_d;

    assign abcdei = rx_code_group[9:4];
    assign fghj   = rx_code_group[3:0];

    always_comb begin
        valid6 = 1'b1;
        edcba  = '0;
        case (abcdei)
            6'b100111, 6'b011000: edcba = 5'd0;
            6'b011101, 6'b100010: edcba = 5'd1;
            6'b101101, 6'b010010: edcba = 5'd2;
            6'b110001:            edcba = 5'd3;
            6'b110101, 6'b001010: edcba = 5'd4;
            6'b101001:            edcba = 5'd5;
            6'b011001:            edcba = 5'd6;
            6'b111000, 6'b000111: edcba = 5'd7;
            6'b111001, 6'b000110: edcba = 5'd8;
            6'b100101:            edcba = 5'd9;
            6'b010101:            edcba = 5'd10;
            6'b110100:            edcba = 5'd11;
            6'b001101:            edcba = 5'd12;
            6'b101100:            edcba = 5'd13;
            6'b011100:            edcba = 5'd14;
            6'b010111, 6'b101000: edcba = 5'd15;
            6'b011011, 6'b100100: edcba = 5'd16;
            6'b100011:            edcba = 5'd17;
            6'b010011:            edcba = 5'd18;
            6'b110010:            edcba = 5'd19;
            6'b001011:            edcba = 5'd20;
            6'b101010:            edcba = 5'd21;
            6'b011010:            edcba = 5'd22;
            6'b111010, 6'b000101: edcba = 5'd23;
            6'b110011, 6'b001100: edcba = 5'd24;
            6'b100110:            edcba = 5'd25;
            6'b010110:            edcba = 5'd26;
            6'b110110, 6'b001001: edcba = 5'd27;
            6'b001110:            edcba = 5'd28;
            6'b101110, 6'b010001: edcba = 5'd29;
            6'b011110, 6'b100001: edcba = 5'd30;
            6'b101011, 6'b010100: edcba = 5'd31;
            default:              valid6 = 1'b0;
        endcase
    end

    always_comb begin
        valid4 = 1'b1;
        hgf    = '0;
        case (fghj)
            4'b1011, 4'b0100: hgf = 3'd0;
            4'b1001:          hgf = 3'd1;
            4'b0101:          hgf = 3'd2;
            4'b1100, 4'b0011: hgf = 3'd3;
            4'b1101, 4'b0010: hgf = 3'd4;
            4'b1010:          hgf = 3'd5;
            4'b0110:          hgf = 3'd6;
            4'b1110, 4'b0001,
            4'b0111, 4'b1000: hgf = 3'd7;
            default:          valid4 = 1'b0;
        endcase
    end

    assign data_valid = valid6 && valid4;
    assign data_octet = {hgf, edcba};

    assign is_k28_5  = (rx_code_group == 10'b0011111010) || (rx_code_group == 10'b1100000101);
    assign is_s      = (rx_code_group == 10'b1101101000) || (rx_code_group == 10'b0010010111);
    assign is_t      = (rx_code_group == 10'b1011101000) || (rx_code_group == 10'b0100010111);
    assign is_r      = (rx_code_group == 10'b1110101000) || (rx_code_group == 10'b0001010111);
    assign is_idle_d = (rx_code_group == 10'b0110110101) || (rx_code_group == 10'b1001000101) ||
                       (rx_code_group == 10'b1010010110);

    // K groups are tested before data: /S/ /T/ /R/ also fall inside the data tables.
    always_comb begin
        state_d = state;
        rxd_d   = '0;
        rx_dv_d = 1'b0;
        rx_er_d = 1'b0;
        if (!sync_status) begin
            state_d = LINK_FAILED;
        end else begin
            case (state)
                LINK_FAILED: state_d = WAIT_FOR_K;
                WAIT_FOR_K: begin
                    if (is_k28_5 && rx_even) state_d = RX_K;
                end
                RX_K: begin
                    state_d = is_idle_d ? IDLE_D : WAIT_FOR_K;
                end
                IDLE_D: begin
                    if (is_k28_5) begin
                        state_d = RX_K;
                    end else if (is_s) begin
                        state_d = RECEIVE;
                        rx_dv_d = 1'b1;
                        rxd_d   = PREAMBLE_OCTET;
                    end else begin
                        state_d = WAIT_FOR_K;
                    end
                end
                RECEIVE: begin
                    if (is_t) begin
                        state_d = END_T;
                    end else if (is_k28_5) begin
                        state_d = RX_K;
                        rx_er_d = 1'b1;
                        rxd_d   = ERR_OCTET;
                    end else if (!is_s && !is_r && data_valid) begin
                        rx_dv_d = 1'b1;
                        rxd_d   = data_octet;
                    end else begin
                        rx_dv_d = 1'b1;
                        rx_er_d = 1'b1;
                        rxd_d   = ERR_OCTET;
                    end
                end
                END_T: begin
                    if (is_r) begin
                        state_d = END_R;
                    end else begin
                        state_d = WAIT_FOR_K;
                        rx_er_d = 1'b1;
                        rxd_d   = ERR_OCTET;
                    end
                end
                END_R: begin
                    if (is_k28_5)  state_d = RX_K;
                    else if (!is_r) state_d = WAIT_FOR_K;
                end
                default: state_d = LINK_FAILED;
            endcase
        end
    end

    always_ff @(posedge GTX_CLK) begin
        if (RESET) begin
            state     <= LINK_FAILED;
            RXD       <= '0;
            RX_DV     <= 1'b0;
            RX_ER     <= 1'b0;
            receiving <= 1'b0;
        end else if (SUDI) begin
            state     <= state_d;
            RXD       <= rxd_d;
            RX_DV     <= rx_dv_d;
            RX_ER     <= rx_er_d;
            receiving <= (state_d == RECEIVE) || (state_d == END_T);
        end
    end

endmodule

// File: tb/tb_pcs_receptor.sv
// Directed bench for pcs_receptor: idles, frames in both disparities, errors,
// SUDI stalls, reset and sync loss, checked with immediate assertions.
module tb_pcs_receptor;

    localparam logic [9:0] K285N = 10'b0011111010;
    localparam logic [9:0] K285P = 10'b1100000101;
    localparam logic [9:0] SN    = 10'b1101101000;
    localparam logic [9:0] SP    = 10'b0010010111;
    localparam logic [9:0] TN    = 10'b1011101000;
    localparam logic [9:0] TP    = 10'b0100010111;
    localparam logic [9:0] RN    = 10'b1110101000;
    localparam logic [9:0] RP    = 10'b0001010111;
    localparam logic [9:0] D162N = 10'b0110110101;
    localparam logic [9:0] D162P = 10'b1001000101;
    localparam logic [9:0] D56   = 10'b1010010110;
    localparam logic [9:0] D215  = 10'b1010101010;
    localparam logic [9:0] D102  = 10'b0101010101;
    localparam logic [9:0] BAD   = 10'b0000000000;

    logic       GTX_CLK = 1'b0;
    logic       RESET;
    logic [9:0] rx_code_group;
    logic       rx_even;
    logic       sync_status;
    logic       SUDI;
    logic [7:0] RXD;
    logic       RX_DV;
    logic       RX_ER;
    logic       receiving;

    int checks = 0;
    int errors = 0;

    pcs_receptor #(
        .PREAMBLE_OCTET(8'h55),
        .ERR_OCTET     (8'h0E)
    ) dut (
        .GTX_CLK      (GTX_CLK),
        .RESET        (RESET),
        .rx_code_group(rx_code_group),
        .rx_even      (rx_even),
        .sync_status  (sync_status),
        .SUDI         (SUDI),
        .RXD          (RXD),
        .RX_DV        (RX_DV),
        .RX_ER        (RX_ER),
        .receiving    (receiving)
    );

    always #5 GTX_CLK = ~GTX_CLK;

    task automatic step(input logic [9:0] cg, input logic ev, input logic sd);
        rx_code_group = cg;
        rx_even       = ev;
        SUDI          = sd;
        @(posedge GTX_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] e_rxd, input logic e_dv,
                       input logic e_er, input logic e_rcv);
        checks++;
        assert (RXD === e_rxd) else begin
            errors++;
            $error("FAIL %s RXD got %h want %h", tag, RXD, e_rxd);
        end
        checks++;
        assert (RX_DV === e_dv) else begin
            errors++;
            $error("FAIL %s RX_DV got %b want %b", tag, RX_DV, e_dv);
        end
        checks++;
        assert (RX_ER === e_er) else begin
            errors++;
            $error("FAIL %s RX_ER got %b want %b", tag, RX_ER, e_er);
        end
        checks++;
        assert (receiving === e_rcv) else begin
            errors++;
            $error("FAIL %s receiving got %b want %b", tag, receiving, e_rcv);
        end
    endtask

    initial begin
        RESET = 1'b1; sync_status = 1'b1; SUDI = 1'b1; rx_even = 1'b0; rx_code_group = D215;
        step(D215, 1'b1, 1'b1);
        step(D215, 1'b0, 1'b1);
        chk("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;

        // idles
        step(K285N, 1'b1, 1'b1); chk("lf_to_wfk", 8'h00, 1'b0, 1'b0, 1'b0);
        step(K285N, 1'b1, 1'b1); chk("wfk_to_rxk", 8'h00, 1'b0, 1'b0, 1'b0);
        step(D162N, 1'b0, 1'b1); chk("idle_d", 8'h00, 1'b0, 1'b0, 1'b0);
        step(K285N, 1'b1, 1'b1); chk("idle_k2", 8'h00, 1'b0, 1'b0, 1'b0);
        step(D162N, 1'b0, 1'b1); chk("idle_d2", 8'h00, 1'b0, 1'b0, 1'b0);
        sync_status = 1'b0;
        step(K285N, 1'b1, 1'b1); chk("sync_loss", 8'h00, 1'b0, 1'b0, 1'b0);
        sync_status = 1'b1;

        // recovery: odd K28.5 must not leave WAIT_FOR_K
        step(K285N, 1'b1, 1'b1);
        step(K285N, 1'b0, 1'b1);
        step(D162N, 1'b1, 1'b1);
        step(SN, 1'b0, 1'b1);    chk("wfk_odd_k", 8'h00, 1'b0, 1'b0, 1'b0);
        step(K285N, 1'b1, 1'b1);
        step(D162N, 1'b0, 1'b1);

        // normal frame, RD- delimiters
        step(SN, 1'b1, 1'b1);    chk("n_pre", 8'h55, 1'b1, 1'b0, 1'b1);
        step(D215, 1'b0, 1'b1);  chk("n_d0", 8'hB5, 1'b1, 1'b0, 1'b1);
        step(D102, 1'b1, 1'b1);  chk("n_d1", 8'h4A, 1'b1, 1'b0, 1'b1);
        step(TN, 1'b0, 1'b1);    chk("n_t", 8'h00, 1'b0, 1'b0, 1'b1);
        step(RN, 1'b1, 1'b1);    chk("n_r", 8'h00, 1'b0, 1'b0, 1'b0);
        step(K285N, 1'b1, 1'b1); chk("n_k", 8'h00, 1'b0, 1'b0, 1'b0);
        step(D162N, 1'b0, 1'b1); chk("n_i", 8'h00, 1'b0, 1'b0, 1'b0);

        // same frame, RD+ delimiters
        step(SP, 1'b1, 1'b1);    chk("p_pre", 8'h55, 1'b1, 1'b0, 1'b1);
        step(D215, 1'b0, 1'b1);  chk("p_d0", 8'hB5, 1'b1, 1'b0, 1'b1);
        step(D102, 1'b1, 1'b1);  chk("p_d1", 8'h4A, 1'b1, 1'b0, 1'b1);
        step(TP, 1'b0, 1'b1);    chk("p_t", 8'h00, 1'b0, 1'b0, 1'b1);
        step(RP, 1'b1, 1'b1);    chk("p_r", 8'h00, 1'b0, 1'b0, 1'b0);
        step(RP, 1'b0, 1'b1);    chk("p_r2", 8'h00, 1'b0, 1'b0, 1'b0);
        step(K285P, 1'b1, 1'b1); chk("p_k", 8'h00, 1'b0, 1'b0, 1'b0);
        step(D162P, 1'b0, 1'b1); chk("p_i", 8'h00, 1'b0, 1'b0, 1'b0);

        // invalid data, /R/ inside frame, early end
        step(SN, 1'b1, 1'b1);    chk("i_pre", 8'h55, 1'b1, 1'b0, 1'b1);
        step(D215, 1'b0, 1'b1);  chk("i_d0", 8'hB5, 1'b1, 1'b0, 1'b1);
        step(BAD, 1'b1, 1'b1);   chk("i_bad", 8'h0E, 1'b1, 1'b1, 1'b1);
        step(RN, 1'b0, 1'b1);    chk("i_r_in_frame", 8'h0E, 1'b1, 1'b1, 1'b1);
        step(D102, 1'b1, 1'b1);  chk("i_resume", 8'h4A, 1'b1, 1'b0, 1'b1);
        step(K285N, 1'b0, 1'b1); chk("early_end", 8'h0E, 1'b0, 1'b1, 1'b0);
        step(D162N, 1'b1, 1'b1); chk("early_idle", 8'h00, 1'b0, 1'b0, 1'b0);

        // D5.6 idle form, then SUDI stall mid-frame
        step(K285N, 1'b0, 1'b1);
        step(D56, 1'b1, 1'b1);   chk("d56_idle", 8'h00, 1'b0, 1'b0, 1'b0);
        step(SN, 1'b0, 1'b1);    chk("s_pre", 8'h55, 1'b1, 1'b0, 1'b1);
        step(D215, 1'b1, 1'b1);  chk("s_d0", 8'hB5, 1'b1, 1'b0, 1'b1);
        step(D102, 1'b0, 1'b0);  chk("stall1", 8'hB5, 1'b1, 1'b0, 1'b1);
        step(D102, 1'b0, 1'b0);  chk("stall2", 8'hB5, 1'b1, 1'b0, 1'b1);
        step(D102, 1'b0, 1'b0);  chk("stall3", 8'hB5, 1'b1, 1'b0, 1'b1);
        step(D102, 1'b0, 1'b1);  chk("s_d1", 8'h4A, 1'b1, 1'b0, 1'b1);
        RESET = 1'b1;
        step(D215, 1'b1, 1'b0);  chk("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;

        // /T/ not followed by /R/
        step(K285N, 1'b1, 1'b1);
        step(K285N, 1'b1, 1'b1);
        step(D162N, 1'b0, 1'b1);
        step(SN, 1'b1, 1'b1);    chk("t_pre", 8'h55, 1'b1, 1'b0, 1'b1);
        step(D215, 1'b0, 1'b1);
        step(TN, 1'b1, 1'b1);    chk("t_t", 8'h00, 1'b0, 1'b0, 1'b1);
        step(K285N, 1'b1, 1'b1); chk("t_no_r", 8'h0E, 1'b0, 1'b1, 1'b0);
        step(D162N, 1'b0, 1'b1); chk("t_wfk", 8'h00, 1'b0, 1'b0, 1'b0);

        // RX_K with non-idle data falls back to WAIT_FOR_K
        step(K285N, 1'b1, 1'b1);
        step(D215, 1'b0, 1'b1);
        step(SN, 1'b1, 1'b1);    chk("rxk_bad", 8'h00, 1'b0, 1'b0, 1'b0);

        // sync loss mid-frame
        step(K285N, 1'b1, 1'b1);
        step(D162N, 1'b0, 1'b1);
        step(SN, 1'b1, 1'b1);    chk("y_pre", 8'h55, 1'b1, 1'b0, 1'b1);
        sync_status = 1'b0;
        step(D215, 1'b0, 1'b1);  chk("y_loss", 8'h00, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcs_receptor.md
Name: pcs_receptor

Overview:
- PCS receive function for the 1000BASE-X link. It sits downstream of `synchronization` and consumes the aligned 10-bit code groups together with rx_even and sync_status.
- It decodes 8b/10b and detects the packet delimiters /S/, /T/ and /R/, plus idles.
- It drives the GMII-style receive outputs RXD, RX_DV and RX_ER. It is the receive-side counterpart of `transmisor`.

Parameters:
- PREAMBLE_OCTET, 8'h55: RXD value substituted for the /S/ code group.
- ERR_OCTET, 8'h0E: RXD value driven while RX_ER=1.

Ports:
- GTX_CLK  input  1  single clock; every block in the design uses this clock.
- RESET  input  1  synchronous, active-high reset.
- rx_code_group  input  10  aligned code group, ordered {a,b,c,d,e,i,f,g,h,j}, with bit 9 = a.
- rx_even  input  1  from synchronization; high on even code-group slots.
- sync_status  input  1  from synchronization; 1 = link synchronized.
- SUDI  input  1  code-group valid strobe. When it is 0, state and all outputs hold.
- RXD  output  8  received octet.
- RX_DV  output  1  receive data valid.
- RX_ER  output  1  receive error.
- receiving  output  1  high in RECEIVE and END_T.

Behaviour:
- **Reset:** state=LINK_FAILED, RXD=8'h00, RX_DV=0, RX_ER=0, receiving=0. Reset overrides SUDI and applies mid-packet without an error indication.
- **Registered outputs:** all outputs are registered. A code group sampled at edge n with SUDI=1 affects outputs after edge n (latency 1 cycle).
- **Decode:** combinational, using the 5b/6b table (abcdei -> EDCBA) and the 3b/4b table (fghj -> HGF). Both running-disparity forms are accepted; running disparity is not checked. Data octet = {HGF, EDCBA}.
- **Recognised K code groups (RD-/RD+):**
  - K28.5: 0011111010 / 1100000101
  - K27.7 /S/: 1101101000 / 0010010111
  - K29.7 /T/: 1011101000 / 0100010111
  - K23.7 /R/: 1110101000 / 0001010111
- **Invalid:** a code group that is in neither table and is not a listed K is invalid.
- **sync_status=0:** in any state, the next state is LINK_FAILED; RX_DV=0, RX_ER=0, RXD=8'h00. This check has priority over every transition below.
- **FSM, evaluated only when SUDI=1 and sync_status=1:**
  - LINK_FAILED -> WAIT_FOR_K.
  - WAIT_FOR_K:
    - K28.5 with rx_even=1 -> RX_K.
    - Otherwise stay.
    - Outputs: RX_DV=0, RX_ER=0.
  - RX_K:
    - D16.2 (0110110101 / 1001000101) or D5.6 (1010010110) -> IDLE_D.
    - Anything else -> WAIT_FOR_K. Configuration ordered sets are not supported.
  - IDLE_D:
    - K28.5 -> RX_K.
    - /S/ -> RECEIVE, with RX_DV=1 and RXD=PREAMBLE_OCTET on the next cycle.
    - Else -> WAIT_FOR_K.
  - RECEIVE:
    - Valid data code group -> stay; RX_DV=1, RXD=decoded octet, RX_ER=0.
    - /T/ -> END_T; RX_DV=0, RX_ER=0.
    - K28.5 (early end) -> RX_K; RX_DV=0, RX_ER=1, RXD=ERR_OCTET for exactly one cycle.
    - Invalid, /S/ or /R/ -> stay; RX_DV=1, RX_ER=1, RXD=ERR_OCTET for that octet.
  - END_T:
    - /R/ -> END_R.
    - Else -> WAIT_FOR_K with RX_ER=1 for one cycle; RX_DV stays 0.
  - END_R:
    - K28.5 -> RX_K.
    - /R/ -> stay.
    - Else -> WAIT_FOR_K.
    - Outputs: RX_DV=0, RX_ER=0.
- **SUDI low:** when SUDI=0 for k cycles, the transitions above are deferred by k cycles.

Test Plan:
- **Reset and sync loss:** RESET=1 for 2 cycles, then sync_status=1, SUDI=1 with repeated /I2/ (K28.5 on even, D16.2) -> RX_DV=0, RX_ER=0, state cycles RX_K/IDLE_D. Then sync_status=0 -> LINK_FAILED next cycle, outputs 0.
- **Normal frame:** idles, /S/, D21.5 (1010101010), D10.2 (0101010101), /T/, /R/, K28.5 -> RXD sequence 8'h55, 8'hB5, 8'h4A, each with RX_DV=1 one cycle after its code group. RX_DV=0 the cycle after /T/. receiving=1 from the /S/+1 cycle to the /R/ cycle.
- **Both disparities:** the same frame sent using the RD+ forms of /S/, /T/, /R/ and K28.5 -> identical RXD and RX_DV waveforms.
- **Invalid data:** 10'b0000000000 mid-frame -> that octet RX_ER=1, RX_DV=1, RXD=8'h0E. The following data resumes with RX_ER=0.
- **Early end:** K28.5 mid-frame -> one cycle RX_ER=1, RX_DV=0, then idle decoding resumes.
- **Mid-frame interruptions:** SUDI held low 3 cycles mid-frame -> RXD/RX_DV frozen for 3 cycles, no error. RESET asserted mid-frame -> all outputs 0 on the next cycle.
